// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime frame format, break detection,
// sticky error flags and a first-word-fall-through receive FIFO.
module uart_rx_param #(
    parameter int DATA_MAX    = 9,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          baud_en_i,
    input  logic                          rx_i,
    input  logic [3:0]                    data_bits_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    input  logic                          rd_en_i,
    input  logic                          err_clr_i,
    output logic [DATA_MAX-1:0]           rx_data_o,
    output logic                          rx_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          parity_err_o,
    output logic                          framing_err_o,
    output logic                          overflow_o,
    output logic                          break_det_o,
    output logic                          rx_idle_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int H  = OVERSAMPLE / 2;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] DMAX4 = 4'(DATA_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                rx_sync;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d, len_q, len_d, len_eff;
    logic [DATA_MAX:0]   shreg_q, shreg_d;
    logic                par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic                stop1_q, stop1_d, s_lo_q, s_mid_q;
    logic                decide, bit_maj, eval, st1, wr_en;
    logic                brk_set, par_set, frm_set, ovf_set;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sync_q <= '1;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
    assign rx_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        len_eff = data_bits_i;
        if (data_bits_i < 4'd5)       len_eff = 4'd5;
        else if (data_bits_i > DMAX4) len_eff = DMAX4;
    end

    // Majority of the three samples straddling mid-bit; decided on the third.
    assign decide  = (cnt_q == CW'(H + 1));
    assign bit_maj = (s_lo_q & s_mid_q) | (s_lo_q & rx_sync) | (s_mid_q & rx_sync);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        stop1_d   = stop1_q;
        len_d     = len_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        eval      = 1'b0;
        st1       = stop1_q;
        wr_en     = 1'b0;
        brk_set   = 1'b0;
        par_set   = 1'b0;
        frm_set   = 1'b0;
        if (baud_en_i) begin
            if (state_q != S_IDLE && state_q != S_BRK_WAIT)
                cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + 1'b1;
            case (state_q)
                S_IDLE: if (!rx_sync) begin
                    state_d   = S_START;
                    cnt_d     = CW'(1);
                    len_d     = len_eff;
                    par_en_d  = parity_en_i;
                    par_odd_d = parity_odd_i;
                    stop2_d   = stop2_i;
                end
                S_START: if (decide) state_d = bit_maj ? S_IDLE : S_DATA;
                S_DATA: if (decide) begin
                    shreg_d[idx_q] = bit_maj;
                    if (idx_q == len_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP1;
                    else                       idx_d = idx_q + 4'd1;
                end
                S_PARITY: if (decide) begin
                    shreg_d[DATA_MAX] = bit_maj;
                    state_d = S_STOP1;
                end
                S_STOP1: if (decide) begin
                    stop1_d = bit_maj;
                    st1     = bit_maj;
                    if (stop2_q) state_d = S_STOP2;
                    else         eval = 1'b1;
                end
                S_STOP2:    if (decide) eval = 1'b1;
                S_BRK_WAIT: if (rx_sync) state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
        if (eval) begin
            if (shreg_q[DATA_MAX-1:0] == '0 && !(par_en_q && shreg_q[DATA_MAX]) && !st1) begin
                brk_set = 1'b1;
                state_d = S_BRK_WAIT;
            end else begin
                wr_en   = 1'b1;
                par_set = par_en_q &&
                          (shreg_q[DATA_MAX] != (^shreg_q[DATA_MAX-1:0] ^ par_odd_q));
                frm_set = !st1 || (state_q == S_STOP2 && !bit_maj);
                state_d = S_IDLE;
            end
        end
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            cnt_d   = '0;
            idx_d   = '0;
            shreg_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            stop1_q   <= 1'b1;
            len_q     <= 4'd5;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            s_lo_q    <= 1'b1;
            s_mid_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            stop1_q   <= stop1_d;
            len_q     <= len_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            if (baud_en_i && cnt_q == CW'(H - 1)) s_lo_q  <= rx_sync;
            if (baud_en_i && cnt_q == CW'(H))     s_mid_q <= rx_sync;
        end
    end

    logic [DATA_MAX-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]       count_q;
    logic                do_rd, do_wr;
    logic                par_err_q, frm_err_q, ovf_q, brk_q;

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign do_rd   = rd_en_i && (count_q != '0);
    assign do_wr   = wr_en && ((count_q != NW'(FIFO_DEPTH)) || do_rd);
    assign ovf_set = wr_en && !do_wr;

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= shreg_q[DATA_MAX-1:0];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
            else if (do_rd && !do_wr) count_q <= count_q - 1'b1;
            par_err_q <= (par_err_q & ~err_clr_i) | par_set;
            frm_err_q <= (frm_err_q & ~err_clr_i) | frm_set;
            ovf_q     <= (ovf_q     & ~err_clr_i) | ovf_set;
            brk_q     <= (brk_q     & ~err_clr_i) | brk_set;
        end
    end

    assign rx_valid_o    = (count_q != '0);
    assign rx_data_o     = rx_valid_o ? mem_q[rd_ptr_q] : '0;
    assign fifo_count_o  = count_q;
    assign parity_err_o  = par_err_q;
    assign framing_err_o = frm_err_q;
    assign overflow_o    = ovf_q;
    assign break_det_o   = brk_q;
    assign rx_idle_o     = (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: stimulus queues expected words, a monitor
// pops the FIFO and compares; flags and occupancy are checked inline.
module tb_uart_rx_param;
    localparam int DM = 9;
    localparam int OS = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          baud_en = 1'b1;
    logic          rx = 1'b1;
    logic [3:0]    data_bits = 4'd8;
    logic          par_en = 1'b0, par_odd = 1'b0, stop2 = 1'b0;
    logic          rd_en = 1'b0, err_clr = 1'b0;
    logic [DM-1:0] rx_data;
    logic          rx_valid;
    logic [2:0]    fifo_count;
    logic          parity_err, framing_err, overflow, break_det, rx_idle;

    int            checks = 0;
    int            errors = 0;
    logic [DM-1:0] exp_q [$];
    bit            auto_read = 1'b0;

    uart_rx_param #(.DATA_MAX(DM), .OVERSAMPLE(OS), .FIFO_DEPTH(FD), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .reset_i(reset), .baud_en_i(baud_en), .rx_i(rx),
        .data_bits_i(data_bits), .parity_en_i(par_en), .parity_odd_i(par_odd),
        .stop2_i(stop2), .rd_en_i(rd_en), .err_clr_i(err_clr),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .fifo_count_o(fifo_count),
        .parity_err_o(parity_err), .framing_err_o(framing_err),
        .overflow_o(overflow), .break_det_o(break_det), .rx_idle_o(rx_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: pops the FIFO head whenever auto_read is on and compares it.
    initial begin
        logic [DM-1:0] e;
        forever begin
            @(negedge clk);
            if (auto_read && rx_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_word: got unexpected 0x%0h, expected none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL rx_word: got 0x%0h, expected 0x%0h", rx_data, e);
                    end else begin
                        $display("ok   rx_word: 0x%0h", rx_data);
                    end
                end
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [8:0] d, input int n, input bit pe, input bit pb,
                              input bit s1, input bit two_stop);
        rx = 1'b0; repeat (OS) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rx = d[i]; repeat (OS) @(negedge clk);
        end
        if (pe) begin rx = pb; repeat (OS) @(negedge clk); end
        rx = s1; repeat (OS) @(negedge clk);
        if (two_stop) begin rx = 1'b1; repeat (OS) @(negedge clk); end
        rx = 1'b1; repeat (2 * OS) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic stop_reading();
        @(posedge clk);
        auto_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check("reset_idle", rx_idle, 1);
        check("reset_valid", rx_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_flags", {parity_err, framing_err, overflow, break_det}, 0);
        check("reset_data", rx_data, 0);
        reset = 1'b0;
        @(negedge clk);
        auto_read = 1'b1;

        // 8N1 0xA5
        exp_q.push_back(9'h0A5);
        send_frame(9'h0A5, 8, 0, 0, 1, 0);
        wait_drain("a5_drain");
        check("a5_flags", {parity_err, framing_err, overflow, break_det}, 0);

        // 9 bits, even parity, two stops: 0x1C3 has five ones -> parity bit 1
        data_bits = 4'd9; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1;
        exp_q.push_back(9'h1C3);
        send_frame(9'h1C3, 9, 1, 1, 1, 1);
        wait_drain("p9_good_drain");
        check("p9_good_perr", parity_err, 0);
        exp_q.push_back(9'h1C3);
        send_frame(9'h1C3, 9, 1, 0, 1, 1);
        wait_drain("p9_bad_drain");
        check("p9_bad_perr", parity_err, 1);
        pulse_clr();
        check("p9_clr_perr", parity_err, 0);

        // 6-tick glitch: detect at tick 3, false start decided 9 ticks later
        data_bits = 4'd8; par_en = 1'b0; stop2 = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_started", rx_idle, 0);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_idle", rx_idle, 1);
        check("glitch_count", fifo_count, 0);
        repeat (2 * OS) @(negedge clk);

        // Overflow with 4-deep FIFO
        stop_reading();
        exp_q.push_back(9'h011); send_frame(9'h011, 8, 0, 0, 1, 0);
        exp_q.push_back(9'h022); send_frame(9'h022, 8, 0, 0, 1, 0);
        exp_q.push_back(9'h033); send_frame(9'h033, 8, 0, 0, 1, 0);
        exp_q.push_back(9'h044); send_frame(9'h044, 8, 0, 0, 1, 0);
        send_frame(9'h0EE, 8, 0, 0, 1, 0);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", rx_data, 9'h011);
        auto_read = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_empty", fifo_count, 0);
        pulse_clr();
        check("ovf_clr", overflow, 0);

        // Break: 12 bit times low
        rx = 1'b0; repeat (12 * OS) @(negedge clk);
        rx = 1'b1; repeat (2 * OS) @(negedge clk);
        check("brk_flag", break_det, 1);
        check("brk_nowrite", fifo_count, 0);
        exp_q.push_back(9'h055);
        send_frame(9'h055, 8, 0, 0, 1, 0);
        wait_drain("brk_next_drain");
        check("brk_next_ferr", framing_err, 0);
        exp_q.push_back(9'h055);
        send_frame(9'h055, 8, 0, 0, 0, 0);
        wait_drain("ferr_drain");
        check("ferr_flag", framing_err, 1);

        // Reset in the middle of DATA with flags set and a word stored
        stop_reading();
        send_frame(9'h03C, 8, 0, 0, 1, 0);
        check("pre_rst_valid", rx_valid, 1);
        rx = 1'b0; repeat (OS) @(negedge clk);
        rx = 1'b1; repeat (OS) @(negedge clk);
        rx = 1'b0; repeat (OS / 2) @(negedge clk);
        check("pre_rst_busy", rx_idle, 0);
        reset = 1'b1; rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_flags", {parity_err, framing_err, overflow, break_det}, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_idle", rx_idle, 1);
        repeat (2 * OS) @(negedge clk);

        // ERR_CLR held through the parity-error write cycle: set wins
        auto_read = 1'b1;
        data_bits = 4'd9; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1;
        exp_q.push_back(9'h1C3);
        fork
            send_frame(9'h1C3, 9, 1, 0, 1, 1);
            begin
                repeat (12 * OS) @(negedge clk);
                err_clr = 1'b1;
                seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    seen = rx_valid;
                end
                err_clr = 1'b0;
                check("clr_race_write_seen", seen, 1);
            end
        join
        wait_drain("clr_race_drain");
        check("clr_race_perr", parity_err, 1);
        check("clr_race_ferr", framing_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
